debounce_scheduler: RTL
=======================

DEBOUNCE_SCHEDULER -- requirements
Module: debounce_scheduler

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of raw button inputs, range 2..8.
REQ-002 SHALL have parameter CNT_MAX, default 1_999_999: last count of the shared filter timer (20 ms at 100 MHz).
REQ-003 SHALL have parameter CNT_W, default 21: timer width, with CNT_MAX < 2^CNT_W.
REQ-004 SHALL have ports: clk in 1, system clock; rst_n in 1, reset.
REQ-005 SHALL have ports: PB in N_BTN, raw active-low buttons with idle level 1; PB_level out N_BTN, debounced level per button; PB_down out N_BTN, one-cycle press pulse per button.
REQ-006 SHALL have ports: evt_valid out 1, press event pending; evt_id out clog2(N_BTN), index of the pressed button; evt_ovf out 1, sticky flag for a lost event; evt_ack in 1, consumer acknowledge; busy out 1, shared timer in use.
REQ-007 SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-008 SHALL pass each PB bit through a 2-flop synchronizer, giving sync[i].
REQ-009 SHALL time-share one CNT_W-bit timer among all buttons; only one button SHALL be filtered at a time.
REQ-010 SHALL raise request req[i] combinationally whenever sync[i] != PB_level[i].
REQ-011 SHALL run a 2-state FSM: IDLE and FILTER.
REQ-012 SHALL move from IDLE to FILTER on the next edge when any req is high: gnt_id takes the round-robin winner, the timer clears to 0, and busy goes to 1.
REQ-013 SHALL search round-robin starting at ptr and SHALL set ptr to (gnt_id+1) mod N_BTN on every grant; ptr resets to 0.
REQ-014 In FILTER, the timer SHALL increment by 1 per cycle with no wrap; it SHALL not exceed CNT_MAX.
REQ-015 In FILTER with req[gnt_id]=0 (a glitch), the FSM SHALL return to IDLE, clear the timer, and leave PB_level unchanged; abort SHALL have priority over completion.
REQ-016 In FILTER with timer==CNT_MAX and req[gnt_id]=1, the block SHALL set PB_level[gnt_id] to sync[gnt_id] and return to IDLE.
REQ-017 If that new level is 0, PB_down[gnt_id] SHALL pulse 1 for exactly one cycle; a release (new level 1) SHALL produce no pulse.
REQ-018 Latency from the first edge sampling PB[i] low, with the timer idle and no competitor, to PB_down[i] registered high SHALL be CNT_MAX+3 edges.
REQ-019 Requests from non-granted buttons SHALL wait; an edge that reverts before it is granted SHALL be silently dropped.
REQ-020 A press commit SHALL load evt_id with gnt_id and set evt_valid=1.
REQ-021 evt_valid SHALL clear on a cycle where evt_ack=1 and no commit occurs.
REQ-022 A simultaneous ack and press commit SHALL load the new id with evt_valid held at 1 and evt_ovf unchanged.
REQ-023 A press commit while evt_valid=1 and evt_ack=0 SHALL overwrite evt_id with the newest press and set evt_ovf=1.
REQ-024 evt_ovf SHALL clear only on an evt_ack cycle with no simultaneous overflow.
REQ-025 evt_ack while evt_valid=0 SHALL be ignored.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously set: FSM=IDLE, timer=0, ptr=0, gnt_id=0, both synchronizer stages all-1, PB_level all-1, PB_down 0, evt_valid 0, evt_id 0, evt_ovf 0, busy 0.
REQ-027 Reset asserted mid-FILTER SHALL abandon the filter with no PB_down pulse and no event.
REQ-028 After reset release, a button held low SHALL be handled as a fresh press.

Structure
REQ-029 Package debounce_pkg SHALL hold the FSM state encoding and the default CNT_MAX/CNT_W constants.
REQ-030 Sub-module btn_sync SHALL implement the per-bit 2-flop synchronizer and be instantiated per button; the arbiter, timer and event register SHALL stay in debounce_scheduler.

Verification (bench: N_BTN=4, CNT_MAX=15)
REQ-031 Scenario 1: PB[2] low from edge 0 and held -> PB_down[2]=1 for one cycle at edge 18; evt_valid=1 and evt_id=2 until ack.
REQ-032 Scenario 2: PB[1] low for 6 cycles then high -> FILTER aborts, no PB_down, PB_level[1] stays 1, busy returns 0.
REQ-033 Scenario 3: PB[0] and PB[3] low on the same edge with ptr=0 -> button 0 filtered first; button 3 granted the edge after button 0 commits; PB_down pulses 17 cycles apart.
REQ-034 Scenario 4: two presses committed with no ack -> evt_id = the second button and evt_ovf=1; one ack -> evt_valid=0 and evt_ovf=0.
REQ-035 Scenario 5: ack on the same cycle as a commit -> evt_valid stays 1 with the new id and evt_ovf=0.
REQ-036 Scenario 6: rst_n low at timer=8 while PB[2] is held low -> all outputs reset immediately; after release, PB_down[2] fires CNT_MAX+3 edges later.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the time-shared button debouncer: FSM encoding,
// default timer constants and the round-robin index helper.
package debounce_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_FILTER = 1'b1
  } state_t;

  localparam int DEF_CNT_MAX = 1_999_999;
  localparam int DEF_CNT_W   = 21;

  // Position 'off' steps past 'base' in a ring of n slots.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one raw button bit; resets to the idle (released) level.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking assignments keep both stages sampling the pre-edge values,
  // so the chain is two flops deep rather than collapsing into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/debounce_scheduler.sv
// N-button debouncer sharing a single filter timer via a round-robin arbiter,
// with a one-deep press-event register and sticky overflow flag.
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter  int N_BTN   = 4,
  parameter  int CNT_MAX = DEF_CNT_MAX,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int ID_W    = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] PB,
  output logic [N_BTN-1:0] PB_level,
  output logic [N_BTN-1:0] PB_down,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_ovf,
  input  logic             evt_ack,
  output logic             busy
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_timer;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_gnt;
  logic [N_BTN-1:0]  r_level;
  logic [N_BTN-1:0]  r_down;
  logic              r_busy;
  logic              r_evt_valid;
  logic [ID_W-1:0]   r_evt_id;
  logic              r_evt_ovf;

  logic [N_BTN-1:0]  w_sync;
  logic [N_BTN-1:0]  w_req;
  logic              w_any;
  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic              w_hit;
  logic              w_done;
  logic              w_press;

  for (genvar g = 0; g < N_BTN; g++) begin : g_sync
    btn_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_async(PB[g]),
      .o_sync (w_sync[g])
    );
  end

  // A button wants the timer whenever its synchronized input disagrees with its committed level.
  assign w_req   = w_sync ^ r_level;
  assign w_any   = |w_req;
  assign w_hit   = w_req[r_gnt];
  assign w_done  = (r_timer == CNT_W'(CNT_MAX));
  assign w_press = (r_state == ST_FILTER) && w_hit && w_done && !w_sync[r_gnt];

  // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int off = 0; off < N_BTN; off++) begin
      if (!w_found && w_req[rr_index(int'(r_ptr), off, N_BTN)]) begin
        w_win   = ID_W'(rr_index(int'(r_ptr), off, N_BTN));
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_level <= '1;
      r_down  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_down <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_FILTER;
            r_gnt   <= w_win;
            r_ptr   <= ID_W'(rr_index(int'(w_win), 1, N_BTN));
            r_timer <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_FILTER: begin
          // A glitch on the granted button wins over a coincident timer expiry.
          if (!w_hit) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_busy  <= 1'b0;
          end else if (w_done) begin
            r_level[r_gnt] <= w_sync[r_gnt];
            r_down[r_gnt]  <= !w_sync[r_gnt];
            r_state        <= ST_IDLE;
            r_timer        <= '0;
            r_busy         <= 1'b0;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A new press always lands; it flags overflow only if the previous one was never acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_ovf   <= 1'b0;
    end else if (w_press) begin
      r_evt_valid <= 1'b1;
      r_evt_id    <= r_gnt;
      if (r_evt_valid && !evt_ack) r_evt_ovf <= 1'b1;
    end else if (evt_ack && r_evt_valid) begin
      r_evt_valid <= 1'b0;
      r_evt_ovf   <= 1'b0;
    end
  end

  assign PB_level  = r_level;
  assign PB_down   = r_down;
  assign busy      = r_busy;
  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_ovf   = r_evt_ovf;

endmodule
